// File: rtl/rx_uart_module_pkg.sv
// Shared UART definitions: frame-state encoding and default 50 MHz / 9600 baud bit timing.
package rx_uart_module_pkg;

  localparam int unsigned UartClksPerBit = 5208;
  localparam int unsigned UartHalfBit    = 2604;
  localparam int unsigned UartCntW       = 13;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/rx_bps_module.sv
// Receive bit timer: counts CLK cycles within a bit and strobes at the bit centre.
module rx_bps_module
  import rx_uart_module_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit,
  parameter int unsigned HALF_BIT     = UartHalfBit
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Count_Sig,
  output logic BPS_CLK
);

  logic [UartCntW-1:0] cnt_q, cnt_d;

  // Counter sits at zero whenever counting is disabled, so a new frame always starts from 0.
  always_comb begin
    cnt_d = '0;
    if (Count_Sig && (cnt_q != UartCntW'(CLKS_PER_BIT - 1))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign BPS_CLK = Count_Sig && (cnt_q == UartCntW'(HALF_BIT));

endmodule

// File: rtl/rx_uart_module.sv
// 8N1 UART receiver: synchronizes the line, detects the start edge and samples each bit centre.
module rx_uart_module
  import rx_uart_module_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit,
  parameter int unsigned HALF_BIT     = UartHalfBit
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Pin_In,
  input  logic       Rx_En_Sig,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Frame_Err_Sig,
  output logic       Rx_Busy
);

  uart_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        line;
  logic        fall;
  logic        strobe;
  logic        count_en;

  assign line = sync2_q;
  assign fall = prev_q && !sync2_q && Rx_En_Sig && (state_q == StIdle);

  // Counting stops the same cycle enable drops, so the counter is already 0 when IDLE is entered.
  assign count_en = (state_q != StIdle) && Rx_En_Sig;

  rx_bps_module #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_bps (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Count_Sig(count_en),
    .BPS_CLK  (strobe)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!Rx_En_Sig) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fall) state_d = StStart;
        end
        StStart: begin
          if (strobe) begin
            if (!line) begin
              state_d = StData;
              idx_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          if (strobe) begin
            shift_d[idx_q] = line;
            if (idx_q == 3'd7) state_d = StStop;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        StStop: begin
          // Leave at the stop-bit centre so a back-to-back start edge is not missed.
          if (strobe) begin
            state_d = StIdle;
            if (line) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign Rx_Data       = data_q;
  assign Rx_Done_Sig   = done_q;
  assign Frame_Err_Sig = err_q;
  assign Rx_Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_rx_uart_module.sv
// Directed bench for rx_uart_module: a fast-timing instance (16/8) plus a default-timing instance.
module tb_rx_uart_module;

  localparam int unsigned Cpb    = 16;
  localparam int unsigned CpbDef = 5208;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       en = 1'b1;
  logic [7:0] data;
  logic       done, err, busy;
  logic       rx_def = 1'b1;
  logic [7:0] def_data;
  logic       def_done, def_err, def_busy;

  int compared = 0;
  int failed   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int def_done_cnt = 0;
  int def_err_cnt  = 0;
  int cyc = 0;
  int def_done_cyc = 0;
  int cyc0 = 0;
  logic [7:0] cap[$];
  logic [7:0] b0, b1;

  always #5 clk = ~clk;

  rx_uart_module #(
    .CLKS_PER_BIT(16),
    .HALF_BIT    (8)
  ) dut (
    .CLK          (clk),
    .RSTn         (rstn),
    .RX_Pin_In    (rx),
    .Rx_En_Sig    (en),
    .Rx_Data      (data),
    .Rx_Done_Sig  (done),
    .Frame_Err_Sig(err),
    .Rx_Busy      (busy)
  );

  rx_uart_module dut_def (
    .CLK          (clk),
    .RSTn         (rstn),
    .RX_Pin_In    (rx_def),
    .Rx_En_Sig    (1'b1),
    .Rx_Data      (def_data),
    .Rx_Done_Sig  (def_done),
    .Frame_Err_Sig(def_err),
    .Rx_Busy      (def_busy)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      cap.push_back(data);
    end
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (def_done) begin
      def_done_cnt++;
      def_done_cyc = cyc;
    end
    if (def_err) def_err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fast_bit(input logic b);
    rx = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fast_bit(1'b0);
    for (int i = 0; i < 8; i++) fast_bit(d[i]);
    fast_bit(stop);
    rx = 1'b1;
  endtask

  task automatic def_bit(input logic b);
    rx_def = b;
    repeat (CpbDef) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_data", 32'(data), 32'h00);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    idle(4);
    check("post_reset_busy", 32'(busy), 32'h0);

    // 0xA3 with a good stop bit
    fast_bit(1'b0);
    check("a3_busy_mid", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) fast_bit(8'hA3 >> i & 8'h01 ? 1'b1 : 1'b0);
    fast_bit(1'b1);
    check("a3_busy_after_stop", 32'(busy), 32'h0);
    idle(Cpb);
    check("a3_data", 32'(data), 32'hA3);
    check("a3_done_cnt", 32'(done_cnt), 32'd1);
    check("a3_err_cnt", 32'(err_cnt), 32'd0);

    // 3-cycle low glitch
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("glitch_done_cnt", 32'(done_cnt), 32'd1);
    check("glitch_err_cnt", 32'(err_cnt), 32'd0);
    check("glitch_data", 32'(data), 32'hA3);
    check("glitch_busy", 32'(busy), 32'h0);

    // 0x55 with stop bit 0
    send_frame(8'h55, 1'b0);
    idle(2 * Cpb);
    check("ferr_err_cnt", 32'(err_cnt), 32'd1);
    check("ferr_done_cnt", 32'(done_cnt), 32'd1);
    check("ferr_data", 32'(data), 32'hA3);

    // Back-to-back 0x00 then 0xFF
    cap.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * Cpb);
    b0 = (cap.size() > 0) ? cap[0] : 8'hxx;
    b1 = (cap.size() > 1) ? cap[1] : 8'hxx;
    check("b2b_done_cnt", 32'(done_cnt), 32'd3);
    check("b2b_first", 32'(b0), 32'h00);
    check("b2b_second", 32'(b1), 32'hFF);
    check("b2b_data", 32'(data), 32'hFF);

    // Enable dropped at data bit 4 of 0x96
    fast_bit(1'b0);
    for (int i = 0; i < 4; i++) fast_bit(8'h96 >> i & 8'h01 ? 1'b1 : 1'b0);
    rx = 1'b1;
    en = 1'b0;
    idle(1);
    check("en_drop_busy", 32'(busy), 32'h0);
    idle(Cpb - 1);
    fast_bit(1'b0);
    fast_bit(1'b0);
    fast_bit(1'b1);
    fast_bit(1'b1);
    idle(Cpb);
    en = 1'b1;
    idle(2 * Cpb);
    check("en_drop_done_cnt", 32'(done_cnt), 32'd3);
    check("en_drop_err_cnt", 32'(err_cnt), 32'd1);
    check("en_drop_data", 32'(data), 32'hFF);
    check("en_drop_busy_end", 32'(busy), 32'h0);

    // Reset pulsed mid-frame (0xFF, line high during data bit 2)
    fast_bit(1'b0);
    fast_bit(1'b1);
    fast_bit(1'b1);
    rx = 1'b1;
    idle(4);
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    rstn = 1'b0;
    idle(2);
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) fast_bit(1'b1);
    idle(2 * Cpb);
    check("rst_after_done_cnt", 32'(done_cnt), 32'd3);
    check("rst_after_err_cnt", 32'(err_cnt), 32'd1);
    check("rst_after_data", 32'(data), 32'h00);
    check("rst_after_busy", 32'(busy), 32'h0);
    check("rst_after_done", 32'(done), 32'h0);
    check("rst_after_err", 32'(err), 32'h0);

    // Default timing: 0x3C at 5208 clocks per bit
    idle(1);
    cyc0 = cyc;
    def_bit(1'b0);
    for (int i = 0; i < 8; i++) def_bit(8'h3C >> i & 8'h01 ? 1'b1 : 1'b0);
    def_bit(1'b1);
    idle(CpbDef);
    check("def_data", 32'(def_data), 32'h3C);
    check("def_done_cnt", 32'(def_done_cnt), 32'd1);
    check("def_err_cnt", 32'(def_err_cnt), 32'd0);
    // Sync (3) + start centre (2605) + 9 bits (46872) edges after the launching edge
    check("def_done_timing", 32'(def_done_cyc - cyc0), 32'd49480);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/rx_uart_module.md
RX_UART_MODULE -- requirements
Module: rx_uart_module

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208: CLK cycles per UART bit (50 MHz / 9600 baud).
REQ-002 Parameter HALF_BIT, default 2604: bit-counter value at which the line is sampled (bit centre).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 RX_Pin_In  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Rx_En_Sig  input  1  receive enable; low holds the block in IDLE.
REQ-007 Rx_Data  output  8  last correctly framed byte.
REQ-008 Rx_Done_Sig  output  1  one-cycle pulse when Rx_Data is updated.
REQ-009 Frame_Err_Sig  output  1  one-cycle pulse when a stop bit samples 0.
REQ-010 Rx_Busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-011 RX_Pin_In shall pass through a 2-flop synchronizer before use; a third flop shall provide the previous value for edge detection.
REQ-012 Falling edge = previous 1, current 0 (synchronized), qualified by Rx_En_Sig and state IDLE.
REQ-013 Bit counter: 13 bits; clears on entry to START; increments each cycle while not IDLE; wraps to 0 after CLKS_PER_BIT-1; sample strobe when count == HALF_BIT.
REQ-014 States: IDLE, START, DATA, STOP; 3-bit bit index for DATA.
REQ-015 IDLE -> START on falling edge, in the cycle after detection.
REQ-016 START at strobe: line 0 -> DATA with index 0; line 1 -> IDLE (glitch rejected, no pulse).
REQ-017 DATA at strobe: shift sampled bit into shift register at position index (LSB first); index 7 -> STOP, else index+1.
REQ-018 STOP at strobe: line 1 -> load Rx_Data from shift register, assert Rx_Done_Sig next cycle for exactly one cycle, go IDLE.
REQ-019 STOP at strobe: line 0 -> assert Frame_Err_Sig next cycle for exactly one cycle, Rx_Data unchanged, go IDLE.
REQ-020 Return to IDLE at the stop-bit centre so a following start bit is accepted back-to-back; a line held low (break) shall not re-trigger until it returns high then falls.
REQ-021 Rx_En_Sig low in any state: next cycle IDLE, counter 0, no pulse; Rx_Data retained.
REQ-022 Rx_Done_Sig and Frame_Err_Sig shall never be high in the same cycle.
REQ-023 Rx_Busy = (state != IDLE), registered-state derived, no extra latency.

Reset
REQ-024 RSTn low: state IDLE, counter 0, index 0, shift register 0x00, Rx_Data 0x00, Rx_Done_Sig 0, Frame_Err_Sig 0, Rx_Busy 0, synchronizer flops 1 (idle line).
REQ-025 Reset mid-frame shall abort the frame with no pulse; after release a new falling edge is required.

Structure
REQ-026 State encodings and default CLKS_PER_BIT/HALF_BIT (50 MHz, 9600 baud) shall live in the shared UART package used by the TX path.
REQ-027 Bit timing shall be a sub-module rx_bps_module (CLK, RSTn, Count_Sig in, BPS_CLK strobe out), mirroring the TX timing block; control FSM and data path remain in rx_uart_module.

Verification (CLKS_PER_BIT=16, HALF_BIT=8 unless stated)
REQ-028 Send 0xA3, stop=1 -> Rx_Data=0xA3, one Rx_Done_Sig pulse, Frame_Err_Sig stays 0, Rx_Busy low after stop centre.
REQ-029 Low glitch of 3 cycles on idle line -> START aborts at strobe, no pulses, Rx_Data unchanged.
REQ-030 Send 0x55 with stop=0 -> one Frame_Err_Sig pulse, no Rx_Done_Sig, Rx_Data keeps prior 0xA3.
REQ-031 Back-to-back 0x00 then 0xFF, no idle gap -> two Done pulses, Rx_Data 0x00 then 0xFF.
REQ-032 Rx_En_Sig dropped at data bit 4, then RSTn pulsed mid-frame on a second frame -> no pulses either time; all outputs at reset values after RSTn.
REQ-033 Default parameters (5208/2604), send 0x3C at 9600 baud -> Rx_Done_Sig pulse one cycle after stop-bit centre, Rx_Data=0x3C.
